// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl : pipeline hazard controller
//
// Turns per-stage stall requests into a per-register hold vector using
// "stall the requesting stage and everything upstream". It also runs a
// registered flush/redirect sequencer and a consecutive-stall watchdog.
//
// Ports
//   clk           in   clock (single domain)
//   rst           in   synchronous active-high reset
//   stallreq      in   [STAGES-1:0] bit i = stall request from stage i+1
//   flushreq      in   flush/redirect request, sampled on rising clk
//   flush_pc_in   in   [31:0] redirect target, captured with flushreq
//   stall         out  [STAGES:0] bit 0 = PC, bit s = reg after stage s
//   flush         out  clear pipeline registers / load new_pc into PC
//   new_pc        out  [31:0] registered redirect target
//   stall_cycles  out  [CNT_W-1:0] consecutive stalled cycles (saturating)
//   stall_timeout out  sticky watchdog flag
// ---------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int STAGES       = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MAX_STALL    = 64,
  parameter int CNT_W        = $clog2(MAX_STALL + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              flushreq,
  input  logic [31:0]       flush_pc_in,
  output logic [STAGES:0]   stall,
  output logic              flush,
  output logic [31:0]       new_pc,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              stall_timeout
);

  localparam int               FC_W    = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]  FC_LOAD = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_STALL);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FLUSH = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [FC_W-1:0]  r_fcnt, w_fcnt_next;
  logic [31:0]      r_new_pc, w_new_pc_next;
  logic [CNT_W-1:0] r_stall_cycles, w_stall_cycles_next;
  logic             r_timeout, w_timeout_next;
  logic [STAGES:0]  w_stall_raw;
  logic [STAGES:0]  w_stall;

  // Register s must hold when any stage at or downstream of stage s requests
  // a stall, i.e. bit s = OR of stallreq[STAGES-1:s-1]. Bit 0 (PC) holds on
  // any request. This yields the "highest requester wins" thermometer code.
  genvar gi;
  generate
    for (gi = 0; gi <= STAGES; gi++) begin : g_stall
      if (gi == 0) begin : g_pc
        assign w_stall_raw[gi] = |stallreq;
      end else begin : g_reg
        assign w_stall_raw[gi] = |stallreq[STAGES-1:gi-1];
      end
    end
  endgenerate

  // flush comes straight from the state register; no path from flushreq.
  assign flush   = (r_state == S_FLUSH);
  assign w_stall = (rst || flush) ? '0 : w_stall_raw;

  assign stall         = w_stall;
  assign new_pc        = r_new_pc;
  assign stall_cycles  = r_stall_cycles;
  assign stall_timeout = r_timeout;

  always_comb begin
    w_state_next        = r_state;
    w_fcnt_next         = r_fcnt;
    w_new_pc_next       = r_new_pc;
    w_stall_cycles_next = r_stall_cycles;
    w_timeout_next      = r_timeout;

    // Flush sequencer: a new request always (re)starts the sequence so the
    // newest redirect wins and back-to-back requests leave no idle gap.
    case (r_state)
      S_IDLE: begin
        if (flushreq) begin
          w_state_next  = S_FLUSH;
          w_fcnt_next   = FC_LOAD;
          w_new_pc_next = flush_pc_in;
        end
      end
      S_FLUSH: begin
        if (flushreq) begin
          w_fcnt_next   = FC_LOAD;
          w_new_pc_next = flush_pc_in;
        end else if (r_fcnt == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_fcnt_next = r_fcnt - 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_fcnt_next  = '0;
      end
    endcase

    // Watchdog: flush cycles already show stall = 0, so they reset the run.
    if (|w_stall) begin
      if (r_stall_cycles != MAX_C) begin
        w_stall_cycles_next = r_stall_cycles + 1'b1;
      end
      if (r_stall_cycles == MAX_C - 1'b1) begin
        w_timeout_next = 1'b1;
      end
    end else begin
      w_stall_cycles_next = '0;
    end

    // An accepted flush is the recovery action, so it clears the flag even
    // if the same edge would have set it.
    if (flushreq) begin
      w_timeout_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_fcnt         <= '0;
      r_new_pc       <= '0;
      r_stall_cycles <= '0;
      r_timeout      <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_fcnt         <= w_fcnt_next;
      r_new_pc       <= w_new_pc_next;
      r_stall_cycles <= w_stall_cycles_next;
      r_timeout      <= w_timeout_next;
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline hazard controller for the STPU core, sitting beside the pipeline registers and the PC. It turns per-stage stall requests into a per-register stall vector using "stall the requesting stage and everything upstream" semantics. It adds a registered flush sequencer that carries a redirect PC for exceptions and branches. A consecutive-stall watchdog flags pipelines that never drain.

## Interface
Parameters:
- STAGES, 5: pipeline stages (IF=1 … WB=STAGES); stall vector is STAGES+1 bits wide.
- FLUSH_CYCLES, 1: cycles `flush` stays high per accepted flush request (≥1).
- MAX_STALL, 64: consecutive stalled cycles before `stall_timeout` sets (≥1).
- CNT_W, $clog2(MAX_STALL+1): width of the stall counter.

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset (`RstEnable` = 1).
- stallreq  in  STAGES  bit i = stall request from stage i+1 (bit 1 = ID, bit 2 = EX).
- flushreq  in  1  flush/redirect request, sampled on rising clk.
- flush_pc_in  in  32  redirect target, captured with flushreq.
- stall  out  STAGES+1  bit 0 = PC, bit s = pipeline register after stage s; 1 = hold.
- flush  out  1  clear all pipeline registers and load `new_pc` into PC.
- new_pc  out  32  registered redirect target, valid while flush = 1.
- stall_cycles  out  CNT_W  consecutive cycles with stall ≠ 0, saturating at MAX_STALL.
- stall_timeout  out  1  sticky watchdog flag.

## Operation
- Stall encoding: k = highest set index in stallreq; stall[k+1:0] = all ones, upper bits 0; stallreq = 0 gives stall = 0. Higher (downstream) stage wins when several request together. With STAGES=5: ID request gives 000111; EX request gives 001111.
- The stall vector is combinational from stallreq, flush state and rst.
- stall is forced to 0 when rst = 1 or flush = 1. A flush overrides every stall request.
- Flush FSM has two states: IDLE and FLUSH.
  - IDLE → FLUSH: flushreq = 1 at a clk edge. Capture flush_pc_in into new_pc and load the flush counter with FLUSH_CYCLES−1.
  - In FLUSH: flush = 1. Each edge decrements the counter. Return to IDLE at the edge where the counter is 0 and flushreq = 0.
  - flushreq = 1 while in FLUSH: recapture new_pc from flush_pc_in and reload the counter. The newest redirect wins.
- new_pc holds its last value in IDLE. It is not cleared after a flush.
- Watchdog, per edge:
  - stall ≠ 0: stall_cycles increments, saturating at MAX_STALL.
  - stall = 0: stall_cycles clears to 0.
  - Flush cycles count as stall = 0.
  - stall_timeout sets on the edge where stall_cycles would reach MAX_STALL. It stays set until rst or until an accepted flushreq; the clear occurs at the same edge as the flush entry.
- Reset values: flush 0, new_pc 32'h0, stall_cycles 0, stall_timeout 0, FSM IDLE, flush counter 0, stall all zeros.
- rst mid-flush aborts the flush at that edge. All outputs take their reset values, and a flushreq sampled in the same cycle as rst is dropped.

## Timing
- stall: zero-latency combinational path from stallreq, same cycle.
- flush / new_pc: one-cycle latency. flushreq high at edge n gives flush high in cycles n+1 … n+FLUSH_CYCLES.
- flush: driven only from state registers, with no combinational path from flushreq.
- stall_cycles: registered. It shows the count of stalled cycles up to the previous edge.
- stall_timeout: rises the cycle after the MAX_STALL-th consecutive stalled cycle.
- Back-to-back flushreq pulses keep flush continuously high, with no idle gap.

## Test plan
- Reset: hold rst 3 cycles with stallreq = 5'b11111 and flushreq = 1 → stall = 0, flush = 0, new_pc = 0, stall_timeout = 0 throughout; first cycle after release shows stall = 6'b111111.
- Priority encode (STAGES=5): stallreq = 5'b00010 → stall = 6'b000111; stallreq = 5'b00110 → 6'b001111; stallreq = 5'b10000 → 6'b111111; stallreq = 0 → 6'b000000.
- Flush: flushreq pulse with flush_pc_in = 32'h0000_0040 and FLUSH_CYCLES=2 → flush high for exactly 2 cycles starting next cycle, new_pc = 32'h40; stall = 0 during those cycles despite stallreq = 5'b00100.
- Flush restart: second flushreq with 32'h0000_0080 during the first flush cycle → flush remains high for 2 more cycles, new_pc = 32'h80, no gap.
- Watchdog (MAX_STALL=4): hold stallreq = 5'b00010 for 6 cycles → stall_cycles 1, 2, 3, 4, 4; stall_timeout rises after the 4th stalled cycle and stays high when stallreq drops; next flushreq clears it.
- Mid-flush reset: assert rst in the second cycle of a FLUSH_CYCLES=3 flush → flush = 0 at the next edge, FSM IDLE, new_pc = 0.
